stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/pause/clear sequencer for the sec/min stopwatch counter. Divides clk into a 1 s tick, gates it by state,
//  and drives the counter's enable and clear. Watches the counter's minute value for saturation.
//  Captures lap snapshots on request. Sits between debounced button pulses and the counter datapath.
// PARAMETERS
//  CLK_PER_SEC  50_000_000  clk cycles per counted second (>=2)
//  MAX_MIN      60          minute value at which counting stops (DONE)
//  CW           6           width of second/minute buses
// PORTS
//  clk        in   1    clock
//  rst_n      in   1    asynchronous, active-low reset
//  start_stop in   1    1-cycle pulse: toggle run/pause
//  clear      in   1    1-cycle pulse: stop and zero
//  lap        in   1    1-cycle pulse: capture current time
//  second     in   CW   counter seconds value
//  minute     in   CW   counter minutes value
//  cnt_en     out  1    1-cycle pulse: counter advances one second
//  cnt_clr    out  1    1-cycle pulse: synchronous clear to counter
//  running    out  1    high in RUN
//  done       out  1    high in DONE
//  lap_sec    out  CW   captured seconds
//  lap_min    out  CW   captured minutes
//  lap_vld    out  1    1-cycle pulse when lap_* update
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, all outputs 0.
//  States: IDLE(zeroed) / RUN / PAUSE / DONE.
//   IDLE -start_stop-> RUN. RUN -start_stop-> PAUSE. PAUSE -start_stop-> RUN.
//   RUN -(minute==MAX_MIN)-> DONE. DONE ignores start_stop.
//   clear in any state -> IDLE; cnt_clr pulses the next cycle. Prescaler resets to 0.
//  Prescaler counts 0..CLK_PER_SEC-1, only in RUN. It holds its value in PAUSE,
//   so resuming does not restart a partial second. It wraps to 0 at terminal count.
//  cnt_en: registered, asserted the cycle after prescaler==CLK_PER_SEC-1 while in RUN.
//   Never asserted outside RUN or in the cycle that cnt_clr is asserted.
//  Saturation: minute is sampled each cycle. The first cycle it equals MAX_MIN in RUN,
//   state becomes DONE. No cnt_en in or after that cycle.
//  Priority for simultaneous pulses: clear > start_stop > saturation check > lap.
//   A lap in the same cycle as clear captures 0:0.
//  Lap: lap pulse in RUN/PAUSE/DONE registers {minute,second} into lap_min/lap_sec. lap_vld pulses
//   the next cycle. lap in IDLE is ignored. lap_* hold until the next capture or clear/reset.
//   clear zeroes lap_*.
//  cnt_clr also pulses the cycle after reset deassertion, so counter and controller start aligned.
//  Reset mid-run: async return to IDLE; no cnt_en may glitch out.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined: lap capture logic and lap_* outputs as above.
//  Not defined: lap input ignored; lap_sec/lap_min/lap_vld tied to 0; no lap flops synthesized.
// STRUCTURE
//  Package stopwatch_pkg: state typedef sw_state_t {IDLE,RUN,PAUSE,DONE}, CW default,
//   SEC_PER_MIN=60.
//  Sub-module sw_tick_gen: the prescaler (en, clr in; tick out), parameterised by CLK_PER_SEC.
//  FSM, cnt_en/cnt_clr registering and lap capture live in stopwatch_ctrl.
// TESTING (bench uses CLK_PER_SEC=4, MAX_MIN=2, real counter attached)
//  Reset release -> cnt_clr pulses once, state IDLE, cnt_en stays 0 for 20 cycles.
//  start_stop at t0 -> running=1; cnt_en pulses exactly every 4 cycles.
//   The first pulse is 5 cycles after the start_stop cycle.
//  Run 2 ticks, start_stop, wait 10 cycles, start_stop -> no cnt_en while paused.
//   The next cnt_en follows after the remaining prescaler count, not a full 4.
//  Run until minute==2 -> done=1, running=0, no further cnt_en.
//   start_stop is ignored; clear -> IDLE, cnt_clr pulses.
//  lap at second==3, minute==1 -> lap_vld pulses once, lap_sec=3, lap_min=1.
//   With macro undefined -> lap_vld stays 0.
//  clear and start_stop in the same cycle while RUN -> IDLE, cnt_clr=1, cnt_en=0 that cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch controller slice.
//   sw_state_t   : controller states IDLE / RUN / PAUSE / DONE
//   SW_CW        : default width of the second/minute buses
//   SEC_PER_MIN  : seconds per minute of the attached counter
//   lap_allowed  : true in the states where a lap request is honoured
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_t;

    localparam int SW_CW       = 6;
    localparam int SEC_PER_MIN = 60;

    // A lap is meaningless while the stopwatch sits zeroed in IDLE.
    function automatic logic lap_allowed(input sw_state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_if
// Bundles the button pulses, counter feedback and controller outputs of the
// stopwatch controller.
//   master modport : drives buttons and counter values, observes results
//   slave  modport : the controller itself
// Parameter CW : width of the second/minute and lap buses.
// -----------------------------------------------------------------------------
interface stopwatch_ctrl_if #(
    parameter int CW = stopwatch_pkg::SW_CW
);
    logic          start_stop;
    logic          clear;
    logic          lap;
    logic [CW-1:0] second;
    logic [CW-1:0] minute;
    logic          cnt_en;
    logic          cnt_clr;
    logic          running;
    logic          done;
    logic [CW-1:0] lap_sec;
    logic [CW-1:0] lap_min;
    logic          lap_vld;

    modport master (
        output start_stop, clear, lap, second, minute,
        input  cnt_en, cnt_clr, running, done, lap_sec, lap_min, lap_vld
    );

    modport slave (
        input  start_stop, clear, lap, second, minute,
        output cnt_en, cnt_clr, running, done, lap_sec, lap_min, lap_vld
    );
endinterface

// File: rtl/sw_tick_gen.sv
// -----------------------------------------------------------------------------
// sw_tick_gen
// Prescaler that turns clk into a one-second tick.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count this cycle (controller is genuinely running)
//   clr        : return the count to 0 (has priority over en)
//   tick       : high in the cycle the count sits at CLK_PER_SEC-1 with en
// The count holds while en is low, so a paused second resumes where it left.
// -----------------------------------------------------------------------------
module sw_tick_gen #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int            PW   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] TERM = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] pre_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg <= '0;
        end else if (clr) begin
            pre_reg <= '0;
        end else if (en) begin
            pre_reg <= (pre_reg == TERM) ? '0 : pre_reg + 1'b1;
        end
    end

    assign tick = en && (pre_reg == TERM);

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Run/pause/clear sequencer for the sec/min stopwatch counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : start_stop/clear/lap pulses and second/minute in;
//                cnt_en/cnt_clr to the counter, running/done status,
//                lap_sec/lap_min/lap_vld lap snapshot out
// Parameters: CLK_PER_SEC (clk cycles per second, >=2), MAX_MIN (minute value
// that ends counting), CW (bus width).
// Build option: STOPWATCH_LAP_EN enables lap capture; without it the lap
// input is ignored and the lap outputs are constant 0.
// Input priority within a cycle: clear > start_stop > saturation > lap.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int MAX_MIN     = 60,
    parameter int CW          = SW_CW
) (
    input  logic            clk,
    input  logic            rst_n,
    stopwatch_ctrl_if.slave bus
);
    localparam logic [CW-1:0] MAX_MIN_W = CW'(MAX_MIN);

    sw_state_t state_reg;
    sw_state_t state_next;
    logic      sat;
    logic      pre_en;
    logic      tick;
    logic      rst_done_reg;
    logic      cnt_en_reg;
    logic      cnt_clr_reg;
    logic      running_reg;
    logic      done_reg;

    // Counter has reached the limit while running: stop this very cycle.
    assign sat = (state_reg == RUN) && (bus.minute == MAX_MIN_W);

    // The prescaler only advances in cycles that stay in RUN; a cycle that
    // leaves RUN (pause, clear, saturation) must not consume a count.
    assign pre_en = (state_reg == RUN) && !bus.clear && !bus.start_stop && !sat;

    sw_tick_gen #(
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (bus.clear),
        .tick  (tick)
    );

    always_comb begin
        state_next = state_reg;
        if (bus.clear) begin
            state_next = IDLE;
        end else if (bus.start_stop) begin
            case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = state_reg;   // DONE ignores start_stop
            endcase
        end else if (sat) begin
            state_next = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rst_done_reg <= 1'b0;
            cnt_en_reg   <= 1'b0;
            cnt_clr_reg  <= 1'b0;
            running_reg  <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rst_done_reg <= 1'b1;
            // First cycle out of reset also clears the counter so both start aligned.
            cnt_clr_reg  <= bus.clear || !rst_done_reg;
            // tick already implies pre_en, so no advance collides with a clear.
            cnt_en_reg   <= tick;
            running_reg  <= (state_next == RUN);
            done_reg     <= (state_next == DONE);
        end
    end

    assign bus.cnt_en  = cnt_en_reg;
    assign bus.cnt_clr = cnt_clr_reg;
    assign bus.running = running_reg;
    assign bus.done    = done_reg;

`ifdef STOPWATCH_LAP_EN
    logic [CW-1:0] lap_sec_reg;
    logic [CW-1:0] lap_min_reg;
    logic          lap_vld_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_sec_reg <= '0;
            lap_min_reg <= '0;
            lap_vld_reg <= 1'b0;
        end else if (bus.clear) begin
            // A lap coinciding with clear records the zeroed time 0:0.
            lap_sec_reg <= '0;
            lap_min_reg <= '0;
            lap_vld_reg <= bus.lap && lap_allowed(state_reg);
        end else if (bus.lap && lap_allowed(state_reg)) begin
            lap_sec_reg <= bus.second;
            lap_min_reg <= bus.minute;
            lap_vld_reg <= 1'b1;
        end else begin
            lap_vld_reg <= 1'b0;
        end
    end

    assign bus.lap_sec = lap_sec_reg;
    assign bus.lap_min = lap_min_reg;
    assign bus.lap_vld = lap_vld_reg;
`else
    logic unused_lap_inputs;
    assign unused_lap_inputs = ^{bus.lap, bus.second};

    assign bus.lap_sec = '0;
    assign bus.lap_min = '0;
    assign bus.lap_vld = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Bench for stopwatch_ctrl with CLK_PER_SEC=4, MAX_MIN=2 and a sec/min
// counter attached. A cycle-level reference model built from the controller's
// rules (run-cycle accounting modulo CLK_PER_SEC) is compared every cycle;
// a vector table and hand-written sequences cover the corner cases.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int CPS = 4;
    localparam int MM  = 2;
    localparam int CW  = 6;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic ss  = 1'b0;
    logic clr = 1'b0;
    logic lp  = 1'b0;
    logic [CW-1:0] sec_q;
    logic [CW-1:0] min_q;

    stopwatch_ctrl_if #(.CW(CW)) bus ();

    assign bus.start_stop = ss;
    assign bus.clear      = clr;
    assign bus.lap        = lp;
    assign bus.second     = sec_q;
    assign bus.minute     = min_q;

    stopwatch_ctrl #(
        .CLK_PER_SEC (CPS),
        .MAX_MIN     (MM),
        .CW          (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Attached sec/min counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q <= '0;
            min_q <= '0;
        end else if (bus.cnt_clr) begin
            sec_q <= '0;
            min_q <= '0;
        end else if (bus.cnt_en) begin
            if (sec_q == CW'(SEC_PER_MIN - 1)) begin
                sec_q <= '0;
                min_q <= min_q + 1'b1;
            end else begin
                sec_q <= sec_q + 1'b1;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] outs();
        return {bus.running, bus.done, bus.cnt_en, bus.cnt_clr, bus.lap_vld, bus.lap_sec, bus.lap_min};
    endfunction

    // ---------------- reference model ----------------
    int            m_mode  = M_IDLE;
    int            m_run_cycles = 0;   // RUN cycles elapsed in the current second
    bit            m_first = 1'b0;
    bit            m_valid = 1'b0;
    bit            e_en    = 1'b0;
    bit            e_clr   = 1'b0;
    bit            e_vld   = 1'b0;
    logic [CW-1:0] e_lsec  = '0;
    logic [CW-1:0] e_lmin  = '0;

    initial begin
        int old_mode;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = M_IDLE; m_run_cycles = 0; m_first = 1'b1; m_valid = 1'b1;
                e_en = 1'b0; e_clr = 1'b0; e_vld = 1'b0; e_lsec = '0; e_lmin = '0;
            end else begin
                old_mode = m_mode;
                e_clr    = clr || m_first;
                m_first  = 1'b0;
                e_en     = 1'b0;
                e_vld    = 1'b0;
                if (clr) begin
                    m_mode = M_IDLE;
                    m_run_cycles = 0;
                end else if (ss) begin
                    if (old_mode == M_IDLE || old_mode == M_PAUSE) m_mode = M_RUN;
                    else if (old_mode == M_RUN)                    m_mode = M_PAUSE;
                end else if (old_mode == M_RUN && int'(min_q) == MM) begin
                    m_mode = M_DONE;
                end else if (old_mode == M_RUN) begin
                    m_run_cycles++;
                    if (m_run_cycles == CPS) begin
                        m_run_cycles = 0;
                        e_en = 1'b1;
                    end
                end
`ifdef STOPWATCH_LAP_EN
                if (clr) begin
                    e_lsec = '0;
                    e_lmin = '0;
                    e_vld  = lp && (old_mode != M_IDLE);
                end else if (lp && old_mode != M_IDLE) begin
                    e_lsec = sec_q;
                    e_lmin = min_q;
                    e_vld  = 1'b1;
                end
`endif
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        logic [16:0] exp_v;
        forever begin
            @(negedge clk);
            if (rst_n && m_valid) begin
                exp_v = {m_mode == M_RUN, m_mode == M_DONE, e_en, e_clr, e_vld, e_lsec, e_lmin};
                check("model_cycle", int'(outs()), int'(exp_v));
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        bit ss, clr, lp;
        bit e_run, e_done, e_clr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n;
        int c;
        int r;

        vecs[0] = '{1, 0, 0, 1, 0, 0};   // IDLE -> RUN
        vecs[1] = '{0, 0, 0, 1, 0, 0};
        vecs[2] = '{1, 0, 0, 0, 0, 0};   // RUN -> PAUSE
        vecs[3] = '{0, 0, 1, 0, 0, 0};   // lap while paused
        vecs[4] = '{1, 0, 0, 1, 0, 0};   // PAUSE -> RUN
        vecs[5] = '{1, 1, 0, 0, 0, 1};   // clear beats start_stop
        vecs[6] = '{1, 0, 0, 1, 0, 0};
        vecs[7] = '{0, 1, 0, 0, 0, 1};
        vecs[8] = '{0, 0, 0, 0, 0, 0};

        // Reset and release.
        repeat (3) @(negedge clk);
        check("rst_outputs", int'(outs()), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cnt_clr", bus.cnt_clr, 1);
        check("rst_idle", {bus.running, bus.done}, 0);
        $display("reset released: cnt_clr=%0b running=%0b", bus.cnt_clr, bus.running);
        c = 0;
        repeat (20) begin
            @(negedge clk);
            c += int'(bus.cnt_en) + int'(bus.cnt_clr);
        end
        check("idle_quiet", c, 0);

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            ss = vecs[i].ss; clr = vecs[i].clr; lp = vecs[i].lp;
            @(negedge clk);
            ss = 1'b0; clr = 1'b0; lp = 1'b0;
            check("vec_running", bus.running, vecs[i].e_run);
            check("vec_done",    bus.done,    vecs[i].e_done);
            check("vec_cnt_clr", bus.cnt_clr, vecs[i].e_clr);
            check("vec_cnt_en",  bus.cnt_en,  0);
            $display("vec %0d ss=%0b clr=%0b lap=%0b -> running=%0b done=%0b cnt_clr=%0b",
                     i, vecs[i].ss, vecs[i].clr, vecs[i].lp, bus.running, bus.done, bus.cnt_clr);
        end

        // Start latency and tick spacing.
        ss = 1'b1;
        @(negedge clk);
        ss = 1'b0;
        check("start_running", bus.running, 1);
        n = 1;
        while (!bus.cnt_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_tick_latency", n, 5);
        $display("start: first cnt_en after %0d cycles", n);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.cnt_en && n < 20);
            check("tick_gap", n, 4);
            $display("tick gap %0d cycles", n);
        end

        // Pause two cycles into a second, resume, expect the remainder only.
        repeat (2) @(negedge clk);
        ss = 1'b1;
        @(negedge clk);
        ss = 1'b0;
        check("pause_running", bus.running, 0);
        c = 0;
        repeat (10) begin
            @(negedge clk);
            c += int'(bus.cnt_en);
        end
        check("pause_no_en", c, 0);
        ss = 1'b1;
        @(negedge clk);
        ss = 1'b0;
        n = 1;
        while (!bus.cnt_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("resume_remainder", n, 3);
        $display("resume: cnt_en after %0d cycles", n);

        // Lap at 1:03.
        n = 0;
        while (!(min_q == 1 && sec_q == 3) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_1m03", int'(n < 2000), 1);
        lp = 1'b1;
        @(negedge clk);
        lp = 1'b0;
`ifdef STOPWATCH_LAP_EN
        check("lap_vld", bus.lap_vld, 1);
        check("lap_sec", bus.lap_sec, 3);
        check("lap_min", bus.lap_min, 1);
`else
        check("lap_vld_off", bus.lap_vld, 0);
        check("lap_sec_off", bus.lap_sec, 0);
        check("lap_min_off", bus.lap_min, 0);
`endif
        $display("lap: vld=%0b %0d:%0d", bus.lap_vld, bus.lap_min, bus.lap_sec);
        @(negedge clk);
        check("lap_vld_once", bus.lap_vld, 0);

        // Saturation at MAX_MIN.
        n = 0;
        while (!bus.done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", int'(bus.done), 1);
        check("done_minute", int'(min_q), MM);
        check("done_not_running", bus.running, 0);
        ss = 1'b1;
        @(negedge clk);
        ss = 1'b0;
        c = 0;
        repeat (10) begin
            @(negedge clk);
            c += int'(bus.cnt_en);
        end
        check("done_no_en", c, 0);
        check("done_ignores_ss", bus.done, 1);
        $display("done: minute=%0d done=%0b", min_q, bus.done);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("done_clear_clr", bus.cnt_clr, 1);
        check("done_clear_idle", {bus.running, bus.done}, 0);

        // clear together with start_stop while running.
        ss = 1'b1;
        @(negedge clk);
        ss = 1'b0;
        repeat (2) @(negedge clk);
        ss = 1'b1; clr = 1'b1;
        @(negedge clk);
        ss = 1'b0; clr = 1'b0;
        check("clr_ss_cnt_clr", bus.cnt_clr, 1);
        check("clr_ss_cnt_en", bus.cnt_en, 0);
        check("clr_ss_running", bus.running, 0);
        $display("clear+start_stop: cnt_clr=%0b running=%0b", bus.cnt_clr, bus.running);

        // Randomized pulses, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            r   = int'($urandom_range(0, 999));
            ss  = (r < 15);
            clr = (r == 500);
            lp  = (r >= 950);
            @(negedge clk);
        end
        ss = 1'b0; clr = 1'b0; lp = 1'b0;

        // Asynchronous reset in the middle of a cnt_en pulse.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        ss = 1'b1;
        @(negedge clk);
        ss = 1'b0;
        n = 1;
        while (!bus.cnt_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_en", bus.cnt_en, 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", int'(outs()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerst_cnt_clr", bus.cnt_clr, 1);
        check("rerst_running", bus.running, 0);
        $display("mid-run reset: cnt_clr=%0b running=%0b", bus.cnt_clr, bus.running);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
